// File: rtl/c6ib_bank_writer.sv
// c6ib_bank_writer: distributes a stream of incoming words across four RAM
// banks in round-robin order (bank 0..3 per page), advancing the shared page
// address after bank 3. A pass covers PAGE_NUM pages and ends with a
// one-cycle done pulse. All outputs are registered, one cycle after acceptance.
module c6ib_bank_writer #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int PAGE_NUM = 32
) (
  input  logic              sys_clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic [3:0]        bank_we,
  output logic [ADDR_W-1:0] bank_addr,
  output logic [DATA_W-1:0] bank_wdata,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = ADDR_W + 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(4 * PAGE_NUM - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [3:0]          we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Next-state, word counter and write-port decode; abort overrides everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = '0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = WRITE;
            cnt_d   = '0;
          end
        end
        WRITE: begin
          if (in_valid) begin
            wdata_d = in_data;
            we_d    = 4'(4'b0001 << cnt_q[1:0]);
            addr_d  = cnt_q[CNT_W-1:2];
            // The final word is presented during the DONE cycle; the counter
            // is cleared here instead of wrapping.
            if (cnt_q == CNT_LAST) begin
              state_d = DONE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    busy_d = (state_d == WRITE);
    done_d = (state_d == DONE);
  end

  // State and registered outputs, asynchronously cleared.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bank_we    = we_q;
  assign bank_addr  = addr_q;
  assign bank_wdata = wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_c6ib_bank_writer.sv
// Scoreboard bench for c6ib_bank_writer: expected writes are queued when a
// word is driven and compared when the DUT presents a bank write.
module tb_c6ib_bank_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  // Instance A: default geometry (32 pages)
  logic        start_a, abort_a, valid_a;
  logic [31:0] data_a;
  logic [3:0]  we_a;
  logic [4:0]  addr_a;
  logic [31:0] wdata_a;
  logic        busy_a, done_a;
  // Instance B: single page
  logic        start_b, abort_b, valid_b;
  logic [31:0] data_b;
  logic [3:0]  we_b;
  logic [4:0]  addr_b;
  logic [31:0] wdata_b;
  logic        busy_b, done_b;

  c6ib_bank_writer #(.DATA_W(32), .ADDR_W(5), .PAGE_NUM(32)) dut_a (
    .sys_clk(clk), .rstn(rstn), .start(start_a), .abort(abort_a),
    .in_valid(valid_a), .in_data(data_a), .bank_we(we_a), .bank_addr(addr_a),
    .bank_wdata(wdata_a), .busy(busy_a), .done(done_a)
  );

  c6ib_bank_writer #(.DATA_W(32), .ADDR_W(5), .PAGE_NUM(1)) dut_b (
    .sys_clk(clk), .rstn(rstn), .start(start_b), .abort(abort_b),
    .in_valid(valid_b), .in_data(data_b), .bank_we(we_b), .bank_addr(addr_b),
    .bank_wdata(wdata_b), .busy(busy_b), .done(done_b)
  );

  typedef struct packed {
    logic [3:0]  we;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t qa[$];
  wr_t qb[$];
  logic [6:0] ma_cnt;
  logic [1:0] mb_cnt;
  int unsigned n_checks = 0, n_errors = 0;
  int unsigned done_cnt_a = 0, done_cnt_b = 0, exp_done_a = 0, exp_done_b = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard for instance A
  always @(negedge clk) begin
    wr_t e;
    if (we_a != 4'b0000) begin
      check_eq("a_we_onehot", 64'($countones(we_a)), 64'd1);
      if (qa.size() == 0) begin
        check_eq("a_unexpected_write", 64'(we_a), 64'd0);
      end else begin
        e = qa.pop_front();
        check_eq("a_we", 64'(we_a), 64'(e.we));
        check_eq("a_addr", 64'(addr_a), 64'(e.addr));
        check_eq("a_data", 64'(wdata_a), 64'(e.data));
      end
    end
    if (done_a) begin
      done_cnt_a++;
      check_eq("a_done_with_last", 64'(we_a), 64'h8);
      check_eq("a_done_addr", 64'(addr_a), 64'd31);
      check_eq("a_done_busy", 64'(busy_a), 64'd0);
    end
  end

  // Scoreboard for instance B
  always @(negedge clk) begin
    wr_t e;
    if (we_b != 4'b0000) begin
      if (qb.size() == 0) begin
        check_eq("b_unexpected_write", 64'(we_b), 64'd0);
      end else begin
        e = qb.pop_front();
        check_eq("b_we", 64'(we_b), 64'(e.we));
        check_eq("b_addr", 64'(addr_b), 64'(e.addr));
        check_eq("b_data", 64'(wdata_b), 64'(e.data));
      end
    end
    if (done_b) begin
      done_cnt_b++;
      check_eq("b_done_with_last", 64'(we_b), 64'h8);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pass_a();
    start_a = 1'b1;
    ma_cnt  = '0;
    tick();
    start_a = 1'b0;
    check_eq("a_busy_after_start", 64'(busy_a), 64'd1);
  endtask

  task automatic word_a(input logic [31:0] d, input logic v);
    wr_t e;
    valid_a = v;
    data_a  = d;
    if (v) begin
      e.we   = 4'(4'b0001 << ma_cnt[1:0]);
      e.addr = ma_cnt[6:2];
      e.data = d;
      qa.push_back(e);
      if (ma_cnt == 7'd127) exp_done_a++;
      ma_cnt = ma_cnt + 1'b1;
    end
    tick();
    valid_a = 1'b0;
  endtask

  task automatic abort_pass_a();
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    check_eq("a_abort_busy", 64'(busy_a), 64'd0);
    check_eq("a_abort_we", 64'(we_a), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    wr_t e;
    start_a = 0; abort_a = 0; valid_a = 0; data_a = '0;
    start_b = 0; abort_b = 0; valid_b = 0; data_b = '0;
    ma_cnt = '0; mb_cnt = '0;
    rstn = 1'b1;
    #1 rstn = 1'b0;
    #1;
    check_eq("rst_we", 64'(we_a), 64'd0);
    check_eq("rst_addr", 64'(addr_a), 64'd0);
    check_eq("rst_wdata", 64'(wdata_a), 64'd0);
    check_eq("rst_busy", 64'(busy_a), 64'd0);
    check_eq("rst_done", 64'(done_a), 64'd0);
    check_eq("rst_b_busy", 64'(busy_b), 64'd0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    tick();

    // Full pass, continuous valid, data 1..128
    start_pass_a();
    for (int i = 1; i <= 128; i++) word_a(32'(i), 1'b1);
    repeat (3) tick();
    check_eq("full_done_count", 64'(done_cnt_a), 64'(exp_done_a));
    check_eq("full_done_once", 64'(done_cnt_a), 64'd1);
    check_eq("full_busy_end", 64'(busy_a), 64'd0);
    check_eq("full_queue_empty", 64'(qa.size()), 64'd0);

    // Alternating valid
    start_pass_a();
    for (int i = 0; i < 256; i++) word_a(32'h1000 + 32'(i), (i % 2) == 0);
    repeat (3) tick();
    check_eq("alt_done_count", 64'(done_cnt_a), 64'd2);
    check_eq("alt_queue_empty", 64'(qa.size()), 64'd0);

    // Abort collides with word 50
    start_pass_a();
    for (int i = 0; i < 49; i++) word_a(32'h2000 + 32'(i), 1'b1);
    valid_a = 1'b1; data_a = 32'hDEAD_BEEF; abort_a = 1'b1;
    tick();
    valid_a = 1'b0; abort_a = 1'b0;
    check_eq("abort_we_next", 64'(we_a), 64'd0);
    check_eq("abort_busy", 64'(busy_a), 64'd0);
    repeat (3) tick();
    check_eq("abort_no_done", 64'(done_cnt_a), 64'd2);
    check_eq("abort_queue_empty", 64'(qa.size()), 64'd0);
    start_pass_a();
    for (int i = 0; i < 4; i++) word_a(32'h3000 + 32'(i), 1'b1);
    tick();
    abort_pass_a();

    // Abort and start together in IDLE: stays idle
    start_a = 1'b1; abort_a = 1'b1;
    tick();
    start_a = 1'b0; abort_a = 1'b0;
    check_eq("abort_start_busy", 64'(busy_a), 64'd0);

    // in_valid in IDLE ignored; start during WRITE ignored
    valid_a = 1'b1; data_a = 32'h5555_AAAA;
    repeat (3) tick();
    valid_a = 1'b0;
    check_eq("idle_valid_we", 64'(we_a), 64'd0);
    check_eq("idle_valid_busy", 64'(busy_a), 64'd0);
    start_pass_a();
    for (int i = 0; i < 5; i++) word_a(32'h4000 + 32'(i), 1'b1);
    start_a = 1'b1;
    word_a(32'h4005, 1'b1);
    start_a = 1'b0;
    for (int i = 6; i < 9; i++) word_a(32'h4000 + 32'(i), 1'b1);
    tick();
    check_eq("start_in_write_busy", 64'(busy_a), 64'd1);
    abort_pass_a();

    // Asynchronous reset half-cycle pulse mid-pass
    start_pass_a();
    for (int i = 0; i < 20; i++) word_a(32'h6000 + 32'(i), 1'b1);
    @(negedge clk);
    #1 rstn = 1'b0;
    #1;
    check_eq("mid_rst_we", 64'(we_a), 64'd0);
    check_eq("mid_rst_addr", 64'(addr_a), 64'd0);
    check_eq("mid_rst_wdata", 64'(wdata_a), 64'd0);
    check_eq("mid_rst_busy", 64'(busy_a), 64'd0);
    @(posedge clk);
    #1 rstn = 1'b1;
    repeat (3) tick();
    check_eq("mid_rst_no_done", 64'(done_cnt_a), 64'd2);
    check_eq("mid_rst_idle", 64'(busy_a), 64'd0);
    start_pass_a();
    for (int i = 0; i < 3; i++) word_a(32'h7000 + 32'(i), 1'b1);
    tick();
    abort_pass_a();

    // Single-page geometry
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    check_eq("b_busy", 64'(busy_b), 64'd1);
    for (int i = 0; i < 4; i++) begin
      valid_b = 1'b1;
      data_b  = 32'hA + 32'(i);
      e.we   = 4'(4'b0001 << mb_cnt);
      e.addr = 5'd0;
      e.data = data_b;
      qb.push_back(e);
      if (mb_cnt == 2'd3) exp_done_b++;
      mb_cnt = mb_cnt + 1'b1;
      tick();
    end
    valid_b = 1'b0;
    repeat (3) tick();
    check_eq("b_done_count", 64'(done_cnt_b), 64'(exp_done_b));
    check_eq("b_busy_end", 64'(busy_b), 64'd0);
    check_eq("b_queue_empty", 64'(qb.size()), 64'd0);
    check_eq("a_final_done", 64'(done_cnt_a), 64'(exp_done_a));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
